// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_rcv_pkg.sv
// Shared defaults and width helpers for the bufz bus receiver.
package gf180mcu_fd_sc_mcu9t5v0__bufz_rcv_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_DEPTH        = 4;
    localparam int DEF_IDLE_TIMEOUT = 16;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Idle counter saturates at the timeout value, so it needs to hold 0..timeout.
    function automatic int idle_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_rcv_fifo.sv
// Synchronous FIFO with a registered head-of-queue output that keeps the last
// popped word when empty; a pop frees a slot for a push in the same cycle.
module gf180mcu_fd_sc_mcu9t5v0__bufz_rcv_fifo
    import gf180mcu_fd_sc_mcu9t5v0__bufz_rcv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             do_pop, do_push;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

    always_comb begin
        rd_ptr_next = do_pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        wr_ptr_next = do_push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        count_next  = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + CW'(1);
        else if (do_pop && !do_push)
            count_next = count_reg - CW'(1);
        // The new head may be the word being written this very cycle.
        dout_next = dout_reg;
        if (count_next != '0) begin
            if (do_push && (wr_ptr_reg == rd_ptr_next))
                dout_next = din;
            else
                dout_next = mem[rd_ptr_next];
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == AW'(gi)))
                    mem[gi] <= din;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            dout_reg   <= dout_next;
        end
    end

    assign dout  = dout_reg;
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_rcv.sv
// Reader for a shared bufz tri-state bus: captures driven words into a FIFO,
// exposes them on valid/ready, and reports dropped captures and bus idleness.
module gf180mcu_fd_sc_mcu9t5v0__bufz_rcv
    import gf180mcu_fd_sc_mcu9t5v0__bufz_rcv_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
`ifdef USE_POWER_PINS
    inout  wire                         VDD,
    inout  wire                         VSS,
`endif
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [WIDTH-1:0]            BUS,
    input  logic                        BUS_EN,
    output logic [WIDTH-1:0]            Q,
    output logic                        VALID,
    input  logic                        READY,
    output logic [cnt_width(DEPTH)-1:0] CNT,
    output logic                        OVF,
    output logic                        IDLE
);

    localparam int IW = idle_width(IDLE_TIMEOUT);

    logic          pop;
    logic          full;
    logic          empty;
    logic          ovf_reg;
    logic          idle_reg;
    logic [IW-1:0] idle_cnt_reg, idle_cnt_next;

    // Any enabled driver means the bus carries a word; X/Z bits pass through untouched.
    assign pop = READY && !empty;

    gf180mcu_fd_sc_mcu9t5v0__bufz_rcv_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .srst  (RST),
        .push  (BUS_EN),
        .pop   (pop),
        .din   (BUS),
        .dout  (Q),
        .full  (full),
        .empty (empty),
        .count (CNT)
    );

    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if (BUS_EN)
            idle_cnt_next = '0;
        else if (idle_cnt_reg < IW'(IDLE_TIMEOUT))
            idle_cnt_next = idle_cnt_reg + IW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_reg      <= 1'b0;
            idle_cnt_reg <= '0;
            idle_reg     <= 1'b0;
        end else begin
            if (BUS_EN && full && !pop)
                ovf_reg <= 1'b1;
            idle_cnt_reg <= idle_cnt_next;
            idle_reg     <= (idle_cnt_next == IW'(IDLE_TIMEOUT));
        end
    end

    assign VALID = !empty;
    assign OVF   = ovf_reg;
    assign IDLE  = idle_reg;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__bufz_rcv.sv
// Directed vector table, idle-timer sequences and a randomized run against a
// queue-based reference model of the bus receiver.
module tb_gf180mcu_fd_sc_mcu9t5v0__bufz_rcv;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       rst, bus_en, ready;
    logic [7:0] bus;
    logic [7:0] q;
    logic       valid, ovf, idle;
    logic [2:0] cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__bufz_rcv #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .BUS    (bus),
        .BUS_EN (bus_en),
        .Q      (q),
        .VALID  (valid),
        .READY  (ready),
        .CNT    (cnt),
        .OVF    (ovf),
        .IDLE   (idle)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] bus;
        logic       rdy;
        logic [7:0] q;
        logic       v;
        logic [2:0] c;
        logic       o;
        logic       i;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [7:0] b, input logic rd,
                       input logic [7:0] eq, input logic ev, input logic [2:0] ec,
                       input logic eo, input logic ei);
        vec_t v;
        v.rst = r; v.en = e; v.bus = b; v.rdy = rd;
        v.q = eq; v.v = ev; v.c = ec; v.o = eo; v.i = ei;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string name, input logic [7:0] eq, input logic ev,
                             input logic [2:0] ec, input logic eo, input logic ei);
        checks++;
        if (q !== eq || valid !== ev || cnt !== ec || ovf !== eo || idle !== ei) begin
            errors++;
            $display("FAIL %s: got Q=%h VALID=%b CNT=%0d OVF=%b IDLE=%b, want Q=%h VALID=%b CNT=%0d OVF=%b IDLE=%b",
                     name, q, valid, cnt, ovf, idle, eq, ev, ec, eo, ei);
        end
    endtask

    task automatic check_idle(input string name, input logic ei);
        checks++;
        if (idle !== ei) begin
            errors++;
            $display("FAIL %s: got IDLE=%b, want IDLE=%b", name, idle, ei);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] b, input logic rd);
        rst = r; bus_en = e; bus = b; ready = rd;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    logic       m_ovf;
    int         m_idle_cnt;

    task automatic model_step(input logic r, input logic e, input logic [7:0] b, input logic rd);
        if (r) begin
            m_q.delete();
            m_last = 8'h00; m_ovf = 1'b0; m_idle_cnt = 0;
        end else begin
            if (rd && m_q.size() > 0) m_last = m_q.pop_front();
            if (e) begin
                if (m_q.size() < DEPTH) m_q.push_back(b);
                else m_ovf = 1'b1;
                m_idle_cnt = 0;
            end else if (m_idle_cnt < TO) begin
                m_idle_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; bus_en = 1'b0; bus = '0; ready = 1'b0;

        //   rst en  bus   rdy   Q     V  C  O  I
        add(1, 1, 8'hA5, 0, 8'h00, 0, 0, 0, 0);
        add(1, 1, 8'hA5, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h11, 0, 8'h11, 1, 1, 0, 0);
        add(0, 1, 8'h22, 0, 8'h11, 1, 2, 0, 0);
        add(0, 1, 8'h33, 0, 8'h11, 1, 3, 0, 0);
        add(0, 0, 8'h00, 1, 8'h22, 1, 2, 0, 0);
        add(0, 0, 8'h00, 1, 8'h33, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 8'h33, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 8'h33, 0, 0, 0, 0);
        add(0, 1, 8'hA1, 0, 8'hA1, 1, 1, 0, 0);
        add(0, 1, 8'hA2, 0, 8'hA1, 1, 2, 0, 0);
        add(0, 1, 8'hA3, 0, 8'hA1, 1, 3, 0, 0);
        add(0, 1, 8'hA4, 0, 8'hA1, 1, 4, 0, 0);
        add(0, 1, 8'hEE, 0, 8'hA1, 1, 4, 1, 0);
        add(0, 1, 8'hFF, 1, 8'hA2, 1, 4, 1, 0);
        add(0, 0, 8'h00, 1, 8'hA3, 1, 3, 1, 0);
        add(0, 0, 8'h00, 1, 8'hA4, 1, 2, 1, 0);
        add(0, 0, 8'h00, 1, 8'hFF, 1, 1, 1, 0);
        add(0, 0, 8'h00, 1, 8'hFF, 0, 0, 1, 0);
        add(0, 1, 8'hB1, 0, 8'hB1, 1, 1, 1, 0);
        add(0, 1, 8'hB2, 0, 8'hB1, 1, 2, 1, 0);
        add(0, 1, 8'hB3, 1, 8'hB2, 1, 2, 1, 0);
        add(0, 0, 8'h00, 1, 8'hB3, 1, 1, 1, 0);
        add(0, 0, 8'h00, 0, 8'hB3, 1, 1, 1, 0);
        add(0, 1, 8'hC1, 0, 8'hB3, 1, 2, 1, 0);
        add(0, 1, 8'hC2, 0, 8'hB3, 1, 3, 1, 0);
        add(1, 1, 8'hC3, 1, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'hD1, 0, 8'hD1, 1, 1, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].bus, vecs[i].rdy);
            check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].v, vecs[i].c, vecs[i].o, vecs[i].i);
            $display("vec %0d: rst=%b en=%b bus=%h rdy=%b -> Q=%h V=%b C=%0d O=%b I=%b",
                     i, vecs[i].rst, vecs[i].en, vecs[i].bus, vecs[i].rdy, q, valid, cnt, ovf, idle);
        end

        // Idle timer: threshold, saturation, restart after one driven cycle.
        for (int k = 1; k <= TO - 1; k++) begin
            step(0, 0, 8'h00, 1);
            check_idle($sformatf("idle_low%0d", k), 1'b0);
        end
        step(0, 0, 8'h00, 1);
        check_idle("idle_assert", 1'b1);
        $display("idle: asserted after %0d undriven cycles", TO);
        for (int k = 0; k < 40; k++) begin
            step(0, 0, 8'h00, 1);
            check_idle($sformatf("idle_hold%0d", k), 1'b1);
        end
        step(0, 1, 8'h5A, 1);
        check_idle("idle_clear", 1'b0);
        $display("idle: cleared by one driven cycle");
        for (int k = 1; k <= TO - 1; k++) begin
            step(0, 0, 8'h00, 1);
            check_idle($sformatf("idle_restart%0d", k), 1'b0);
        end
        step(0, 0, 8'h00, 1);
        check_idle("idle_reassert", 1'b1);

        // Randomized run against the reference model.
        step(1, 0, 8'h00, 0);
        model_step(1, 0, 8'h00, 0);
        begin
            int p_en = 50;
            int p_rdy = 50;
            for (int n = 0; n < 3000; n++) begin
                logic r, e, rd;
                logic [7:0] b;
                if (n % 64 == 0) begin
                    p_en  = $urandom_range(0, 4) * 25;
                    p_rdy = $urandom_range(0, 4) * 25;
                end
                r  = ($urandom_range(0, 199) == 0);
                e  = ($urandom_range(0, 99) < p_en);
                rd = ($urandom_range(0, 99) < p_rdy);
                b  = 8'($urandom);
                step(r, e, b, rd);
                model_step(r, e, b, rd);
                check_all($sformatf("rand%0d", n),
                          (m_q.size() > 0) ? m_q[0] : m_last,
                          m_q.size() > 0, 3'(m_q.size()), m_ovf, m_idle_cnt == TO);
                $display("rand %0d: rst=%b en=%b bus=%h rdy=%b -> Q=%h V=%b C=%0d O=%b I=%b",
                         n, r, e, b, rd, q, valid, cnt, ovf, idle);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
